bram_stream_reader: RTL
=======================

# bram_stream_reader

Read-side streaming engine for the feature-map / weight dual-port BRAMs. Takes a burst command (start address, length, optional stride), drives one BRAM port (ce/we/addr/d, 1-cycle registered read), and presents the returned words as a valid/ready stream with last marker to the downstream PE array. It absorbs the BRAM read latency with a 2-entry skid FIFO, so it sustains one word per cycle under continuous ready and loses no data under backpressure.

## Interface
Parameters:
- DWIDTH, 32, data word width; matches BRAM DWIDTH
- AWIDTH, 10, BRAM address width
- MEM_SIZE, 650, BRAM depth in words; address wrap boundary
- LWIDTH, AWIDTH+1, burst length width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_valid  in  1  command valid
- start_ready  out  1  command accepted when start_valid && start_ready
- start_addr  in  AWIDTH  first word address; must be < MEM_SIZE
- start_len  in  LWIDTH  number of words, 0..2^LWIDTH-1
- start_stride  in  AWIDTH  address increment, 1..MEM_SIZE-1 (present only with macro)
- bram_ce  out  1  BRAM port chip enable
- bram_we  out  1  tied 0
- bram_addr  out  AWIDTH  BRAM port address
- bram_d  out  DWIDTH  tied 0
- bram_q  in  DWIDTH  BRAM read data, valid the cycle after bram_ce
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  DWIDTH  stream word
- m_last  out  1  high on final word of burst
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, burst complete

## Operation
- FSM: IDLE, RUN, DRAIN. start_ready = (state == IDLE).
- IDLE: on accept latch addr/len/stride; len==0 -> stay IDLE, pulse done next cycle, no BRAM access, no beats; else -> RUN.
- RUN: issue read (bram_ce=1, bram_addr=cur_addr) when inflight + fifo_count - pop < 2; inflight is the 1-bit flag "read issued last cycle". On issue: cur_addr += stride (1 without macro); if result >= MEM_SIZE subtract MEM_SIZE (wrap). Decrement issue counter; when zero after issue -> DRAIN.
- bram_q is written into FIFO exactly in the cycle after a read was issued (inflight==1); never sampled otherwise (BRAM holds q when ce=0, which must not be re-captured).
- FIFO: 2 entries, registered; m_valid = fifo not empty; m_data/m_last from head. Simultaneous push and pop allowed in any occupancy including full.
- m_last tagged on the word pushed by the final issue.
- DRAIN: no issues; when the last-tagged word handshakes -> IDLE, done pulses that cycle+1... exactly: done asserted in the cycle after the m_last handshake edge, together with return to IDLE.
- busy = (state != IDLE) or done pending.
- m_valid, once high, holds with stable m_data/m_last until m_ready.

## Timing
- Reset (async assert, sync release): state IDLE, start_ready 1, bram_ce 0, bram_addr 0, bram_we 0, bram_d 0, m_valid 0, m_data 0, m_last 0, busy 0, done 0, FIFO empty, inflight 0. Reset mid-burst aborts; no done.
- Accept at edge E0: first bram_ce during cycle after E0; data in FIFO, m_valid high 2 cycles after first ce edge … i.e. first m_valid in the 3rd cycle after E0.
- m_ready held 1: one word per cycle, N words occupy N consecutive cycles.
- m_ready low: at most 2 words buffered; issue stalls; no word dropped or duplicated.
- Next command accepted earliest the cycle done is high.

## Configuration
- BRAM_READER_STRIDE_EN defined: start_stride port present, address advances by latched stride with MEM_SIZE wrap.
- Undefined: no start_stride port; stride fixed at 1, same wrap rule.

## Structure
- Shared package cnn_pkg: FSM state enum (RD_IDLE, RD_RUN, RD_DRAIN), FIFO depth constant (2).
- One sub-module: bram_reader_skid_fifo (2-entry, data+last, push/pop/full/empty).

## Test plan
- BRAM preloaded ram[i]=i; cmd addr 10, len 4, m_ready=1 -> data 10,11,12,13 on 4 consecutive cycles, m_last on 13, single done pulse.
- addr 648, len 4 -> 648, 649, 0, 1 (wrap at MEM_SIZE=650).
- len 8, m_ready toggled random 50% -> exact 0..7 order, no drop/duplicate, bram_ce never asserted when FIFO would overflow.
- len 0 -> done one cycle after accept, m_valid never high, bram_ce never high.
- reset_n pulled low mid-burst after 3 words -> all outputs to reset values immediately; new cmd addr 0 len 2 -> 0,1 correct.
- With BRAM_READER_STRIDE_EN, addr 0, len 3, stride 300 -> 0, 300, 600; addr 600, stride 100, len 2 -> 600, 50.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the CNN BRAM streaming blocks: reader FSM states and skid FIFO depth.
package cnn_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } rd_state_t;

    localparam int unsigned RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_reader_skid_fifo.sv
// Two-entry registered skid FIFO carrying a data word plus its end-of-burst flag.
// Push and pop may coincide at any occupancy, including full.
module bram_reader_skid_fifo
    import cnn_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DWIDTH-1:0] head_data,
    output logic              head_last,
    output logic              full,
    output logic              empty
);

    logic [DWIDTH-1:0] mem_data [RD_FIFO_DEPTH];
    logic              mem_last [RD_FIFO_DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == 2'(RD_FIFO_DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // When full, a push is only legal alongside a pop; it then reuses the slot being vacated.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read engine: drives one BRAM port and streams returned words as valid/ready with last.
// Define BRAM_READER_STRIDE_EN to add the start_stride port; otherwise the address advances by 1.
module bram_stream_reader
    import cnn_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned MEM_SIZE = 650,
    parameter int unsigned LWIDTH   = AWIDTH + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [LWIDTH-1:0] start_len,
`ifdef BRAM_READER_STRIDE_EN
    input  logic [AWIDTH-1:0] start_stride,
`endif
    output logic              bram_ce,
    output logic              bram_we,
    output logic [AWIDTH-1:0] bram_addr,
    output logic [DWIDTH-1:0] bram_d,
    input  logic [DWIDTH-1:0] bram_q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [AWIDTH-1:0] cur_addr;
    logic [AWIDTH-1:0] next_addr;
    logic [AWIDTH:0]   addr_sum;
    logic [AWIDTH-1:0] stride;
    logic [LWIDTH-1:0] issue_cnt;
    logic              inflight;
    logic              inflight_last;
    logic              done_nxt;
    logic              accept;
    logic              issue;
    logic              final_issue;
    logic              pop;
    logic [2:0]        occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_last;

`ifdef BRAM_READER_STRIDE_EN
    logic [AWIDTH-1:0] stride_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stride_q <= AWIDTH'(1);
        end else if (accept) begin
            stride_q <= start_stride;
        end
    end

    assign stride = stride_q;
`else
    assign stride = AWIDTH'(1);
`endif

    assign accept      = start_valid && start_ready;
    assign pop         = m_valid && m_ready;
    assign start_ready = (state == RD_IDLE);
    assign busy        = (state != RD_IDLE) || done;
    assign bram_we     = 1'b0;
    assign bram_d      = '0;
    assign m_valid     = !fifo_empty;
    assign m_last      = head_last;

    // Words already committed (FIFO + read in flight) must fit after this cycle's pop.
    assign occupancy   = 3'(inflight) + (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1));
    assign issue       = (state == RD_RUN) && (occupancy < 3'(RD_FIFO_DEPTH) + 3'(pop));
    assign final_issue = issue && (issue_cnt == LWIDTH'(1));

    assign addr_sum    = {1'b0, cur_addr} + {1'b0, stride};
    assign next_addr   = (addr_sum >= (AWIDTH+1)'(MEM_SIZE))
                       ? AWIDTH'(addr_sum - (AWIDTH+1)'(MEM_SIZE))
                       : AWIDTH'(addr_sum);

    assign bram_ce     = issue;
    assign bram_addr   = issue ? cur_addr : '0;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            RD_IDLE: begin
                if (accept) begin
                    if (start_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RD_RUN;
                    end
                end
            end
            RD_RUN: begin
                if (final_issue) begin
                    state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pop && head_last) begin
                    state_nxt = RD_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RD_IDLE;
            done          <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            cur_addr      <= '0;
            issue_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            done          <= done_nxt;
            inflight      <= issue;
            inflight_last <= final_issue;
            if (accept) begin
                cur_addr  <= start_addr;
                issue_cnt <= start_len;
            end else if (issue) begin
                cur_addr  <= next_addr;
                issue_cnt <= issue_cnt - LWIDTH'(1);
            end
        end
    end

    // bram_q is captured only the cycle after a read; the BRAM holds q otherwise.
    bram_reader_skid_fifo #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (bram_q),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (m_data),
        .head_last (head_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
